// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: FSM states, access sizes and RV32I load/store funct3 encodings.
package load_store_unit_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    function automatic lsu_size_t size_of(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? SZ_B : f3[1:0] == 2'b01 ? SZ_H : SZ_W;
    endfunction
    function automatic logic f3_valid(input logic we, input logic [2:0] f3);
        return we ? f3 inside {F3_SB, F3_SH, F3_SW} : f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the addressed lane down and sign/zero-extends it per load funct3.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] d;
    assign d = rdata >> {offset, 3'b000};
    assign data = funct3 == F3_LB  ? {{24{d[7]}}, d[7:0]}   :
                  funct3 == F3_LBU ? {24'd0, d[7:0]}        :
                  funct3 == F3_LH  ? {{16{d[15]}}, d[15:0]} :
                  funct3 == F3_LHU ? {16'd0, d[15:0]}       : d;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core load/store requests onto a req/gnt/rvalid memory bus.
// Define LSU_MISALIGN_EXC_EN to reject misaligned H/W accesses instead of aligning them down.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_t state, state_n;
    lsu_size_t size;
    logic [CW-1:0] cnt;
    logic [2:0] f3_q;
    logic [1:0] off, off_q;
    logic [3:0] be;
    logic [31:0] wdata, load_data;
    logic bad, timed_out;

    assign size = size_of(req_funct3);
    // Offsets are aligned to the access size; H/W low bits never reach the lane logic.
    assign off = size == SZ_B ? req_addr[1:0] : size == SZ_H ? {req_addr[1], 1'b0} : 2'b00;
    assign be = size == SZ_B ? 4'b0001 << off : size == SZ_H ? 4'b0011 << off : 4'b1111;
    assign wdata = size == SZ_B ? {4{req_wdata[7:0]}} : size == SZ_H ? {2{req_wdata[15:0]}} : req_wdata;
`ifdef LSU_MISALIGN_EXC_EN
    assign bad = !f3_valid(req_we, req_funct3) || (size == SZ_H && req_addr[0]) ||
                 (size == SZ_W && req_addr[1:0] != 2'b00);
`else
    assign bad = !f3_valid(req_we, req_funct3);
`endif
    // >= rather than == so a grant on the last allowed cycle still times out in WAIT.
    assign timed_out = TIMEOUT_CYCLES != 0 && cnt >= LIMIT;

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        req_ready = 1'b0;
        mem_req = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                state_n = !req_valid ? IDLE : bad ? RESP : REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                state_n = mem_gnt ? WAIT : timed_out ? RESP : REQ;
            end
            WAIT: state_n = mem_rvalid || timed_out ? RESP : WAIT;
            RESP: begin
                resp_valid = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            f3_q <= '0;
            off_q <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_be <= '0;
            mem_wdata <= '0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            cnt <= state == REQ || state == WAIT ? cnt + 1'b1 : '0;
            if (state == IDLE && req_valid) begin
                f3_q <= req_funct3;
                off_q <= off;
                mem_we <= req_we;
                mem_addr <= {req_addr[31:2], 2'b00};
                mem_be <= be;
                mem_wdata <= wdata;
                resp_rdata <= '0;
                resp_err <= bad;
            end else if (state == WAIT && mem_rvalid) begin
                resp_rdata <= mem_we ? '0 : load_data;
                resp_err <= 1'b0;
            end else if (state_n == RESP) begin
                resp_rdata <= '0;
                resp_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a lane-arithmetic model.
module tb_load_store_unit;
    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [2:0] req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    int checks = 0, errors = 0;

    logic saw_req, stable, ready_low, after_valid, o_we, r_err;
    logic [31:0] o_addr, o_wdata, r_rdata;
    logic [3:0] o_be;
    int lat, req_cycles;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic int m_size(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int n = m_size(f3);
        return n == 4 ? 0 : int'(a[1:0]) / n * n;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        int n = m_size(f3);
        return n == 1 ? w[7:0] * 32'h01010101 : n == 2 ? w[15:0] * 32'h00010001 : w;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        int n, v;
        logic [31:0] d;
        n = m_size(f3);
        d = r >> (8 * m_off(f3, a));
        if (n == 4) return d;
        v = n == 1 ? int'(d[7:0]) : int'(d[15:0]);
        if (!f3[2] && v >= (n == 1 ? 128 : 32768)) v -= (n == 1 ? 256 : 65536);
        return v;
    endfunction

    function automatic logic m_valid(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic ok = we ? f3 <= 3'd2 : f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
`ifdef LSU_MISALIGN_EXC_EN
        if (m_size(f3) == 2 && a[0]) ok = 1'b0;
        if (m_size(f3) == 4 && a[1:0] != 2'b00) ok = 1'b0;
`else
        if (a[0] === 1'bx) ok = 1'bx;
`endif
        return ok;
    endfunction

    // Bus responder: grants after gd request cycles, answers rd cycles into the wait phase (-1 = never).
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gd, input int rd, input logic [31:0] rdata);
        int g, w;
        logic granted;
        g = 0; w = 0; granted = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        saw_req = 1'b0; stable = 1'b1; ready_low = 1'b1; lat = -1; req_cycles = 0;
        o_addr = 'x; o_be = 'x; o_we = 'x; o_wdata = 'x; r_rdata = 'x; r_err = 'x;
        for (int cyc = 1; cyc < 40 && lat < 0; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (req_ready !== 1'b0) ready_low = 1'b0;
            if (resp_valid === 1'b1) begin
                lat = cyc; r_rdata = resp_rdata; r_err = resp_err;
            end else if (mem_req === 1'b1) begin
                if (!saw_req) begin
                    o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
                end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== {o_addr, o_be, o_we, o_wdata}) stable = 1'b0;
                saw_req = 1'b1;
                req_cycles++;
                if (g == gd) begin mem_gnt = 1'b1; granted = 1'b1; end
                g++;
            end else if (granted) begin
                if (w == rd) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
                w++;
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        after_valid = resp_valid;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b expected 0", resp_err); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata: got %h expected 0", resp_rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_be !== 4'd0) begin errors++; $display("FAIL rst_mem_be: got %b expected 0", mem_be); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h expected 00000100", o_addr); end
        checks++; if (o_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", o_be); end
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", o_we); end
        checks++; if (o_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", o_wdata); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", lat); end
        checks++; if (r_rdata !== 32'd0 || r_err !== 1'b0) begin errors++; $display("FAIL sw_resp: got rdata=%h err=%b expected 0/0", r_rdata, r_err); end
        checks++; if (after_valid !== 1'b0) begin errors++; $display("FAIL sw_pulse_width: got %b expected 0", after_valid); end
        checks++; if (ready_low !== 1'b1) begin errors++; $display("FAIL sw_ready_low: got %b expected 1", ready_low); end
    endtask

    task automatic test_byte_half();
        run_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0);
        checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", o_be); end
        checks++; if (o_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o_wdata); end
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0011);
        checks++; if (r_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", r_rdata); end
        checks++; if (o_we !== 1'b0 || o_be !== 4'b1000) begin errors++; $display("FAIL lb_bus: got we=%b be=%b expected 0/1000", o_we, o_be); end
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0011);
        checks++; if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h expected 00000080", r_rdata); end
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h9ABC1234);
        checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL lh_be: got %b expected 1100", o_be); end
        checks++; if (r_rdata !== 32'hFFFF9ABC) begin errors++; $display("FAIL lh_rdata: got %h expected ffff9abc", r_rdata); end
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h9ABC1234);
        checks++; if (r_rdata !== 32'h00009ABC) begin errors++; $display("FAIL lhu_rdata: got %h expected 00009abc", r_rdata); end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] w = $urandom;
        run_txn(1'b1, 3'b010, 32'h40, w, 5, 0, 32'h0);
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b expected 1", stable); end
        checks++; if (ready_low !== 1'b1) begin errors++; $display("FAIL stall_ready_low: got %b expected 1", ready_low); end
        checks++; if (req_cycles !== 6) begin errors++; $display("FAIL stall_req_cycles: got %0d expected 6", req_cycles); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL stall_latency: got %0d expected 8", lat); end
        checks++; if (o_wdata !== w || r_err !== 1'b0) begin errors++; $display("FAIL stall_data: got wdata=%h err=%b expected %h/0", o_wdata, r_err, w); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'b010, 32'h300, 32'h0, -1, 0, 32'h0);
        checks++; if (lat !== 9) begin errors++; $display("FAIL to_latency: got %0d expected 9", lat); end
        checks++; if (r_err !== 1'b1 || r_rdata !== 32'd0) begin errors++; $display("FAIL to_resp: got err=%b rdata=%h expected 1/0", r_err, r_rdata); end
        checks++; if (req_cycles !== 8) begin errors++; $display("FAIL to_req_cycles: got %0d expected 8", req_cycles); end
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL to_late_rvalid: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); end
        run_txn(1'b0, 3'b010, 32'h304, 32'h0, 1, 1, 32'hCAFEF00D);
        checks++; if (lat !== 5 || r_rdata !== 32'hCAFEF00D || r_err !== 1'b0) begin errors++; $display("FAIL to_next: got lat=%0d rdata=%h err=%b expected 5/cafef00d/0", lat, r_rdata, r_err); end
    endtask

    task automatic test_misalign();
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h13579BDF);
`ifdef LSU_MISALIGN_EXC_EN
        checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b expected 0", saw_req); end
        checks++; if (lat !== 1 || r_err !== 1'b1 || r_rdata !== 32'd0) begin errors++; $display("FAIL mis_err: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, r_err, r_rdata); end
`else
        checks++; if (o_addr !== 32'h100 || o_be !== 4'b1111) begin errors++; $display("FAIL mis_bus: got addr=%h be=%b expected 00000100/1111", o_addr, o_be); end
        checks++; if (r_rdata !== 32'h13579BDF || r_err !== 1'b0) begin errors++; $display("FAIL mis_rdata: got %h err=%b expected 13579bdf/0", r_rdata, r_err); end
`endif
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req: got %b expected 1", mem_req); end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rmid_async: got req=%b valid=%b ready=%b expected 0/0/1", mem_req, resp_valid, req_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (3) begin
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got activity=%b expected 0", seen); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic we = 1'($urandom);
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom, w = $urandom, r = $urandom;
            int gd = $urandom_range(0, 3), rd = $urandom_range(0, 2);
            run_txn(we, f3, a, w, gd, rd, r);
            if (m_valid(we, f3, a) !== 1'b1) begin
                checks++; if (saw_req !== 1'b0 || lat !== 1) begin errors++; $display("FAIL rnd_bad_path[%0d]: got req=%b lat=%0d expected 0/1", i, saw_req, lat); end
                checks++; if (r_err !== 1'b1 || r_rdata !== 32'd0) begin errors++; $display("FAIL rnd_bad_resp[%0d]: got err=%b rdata=%h expected 1/0", i, r_err, r_rdata); end
            end else begin
                checks++; if (o_addr !== {a[31:2], 2'b00} || o_we !== we) begin errors++; $display("FAIL rnd_addr[%0d]: got %h we=%b expected %h/%b", i, o_addr, o_we, {a[31:2], 2'b00}, we); end
                checks++; if (o_be !== m_be(f3, a)) begin errors++; $display("FAIL rnd_be[%0d]: got %b expected %b", i, o_be, m_be(f3, a)); end
                if (we) begin
                    checks++; if (o_wdata !== m_wdata(f3, w)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, o_wdata, m_wdata(f3, w)); end
                end
                checks++; if (stable !== 1'b1 || lat !== gd + rd + 3) begin errors++; $display("FAIL rnd_timing[%0d]: got stable=%b lat=%0d expected 1/%0d", i, stable, lat, gd + rd + 3); end
                checks++; if (r_err !== 1'b0 || r_rdata !== (we ? 32'd0 : m_rdata(f3, a, r))) begin errors++; $display("FAIL rnd_resp[%0d]: got err=%b rdata=%h expected 0/%h", i, r_err, r_rdata, we ? 32'd0 : m_rdata(f3, a, r)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte_half();
        test_gnt_stall();
        test_timeout();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Downstream neighbour of the core datapath. Sits between the ALU result/rs2 path and data memory.
- Accepts one load or store request per transaction over a valid/ready handshake.
- Drives a variable-latency req/gnt/rvalid memory bus with word-aligned address and byte enables.
- Returns sign/zero-extended load data, or a store acknowledge, as a one-cycle response.

Parameters:
TIMEOUT_CYCLES, 256, max cycles spent in REQ+WAIT before aborting with error; 0 disables the timeout.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  error qualifier, valid with resp_valid
mem_req  out  1  bus request
mem_gnt  in  1  bus grant
mem_addr  out  32  word-aligned address, bits [1:0]=0
mem_we  out  1  bus write
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated write data
mem_rvalid  in  1  bus response / write ack
mem_rdata  in  32  bus read data

Behaviour:
- Reset values: req_ready=1; resp_valid, resp_err, mem_req, mem_we = 0; resp_rdata, mem_addr, mem_be, mem_wdata = 0. State=IDLE, timeout counter=0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata, compute be/wdata and go to REQ.
  - Exception: invalid funct3 (load 011/110/111; store ≥011) goes straight to RESP with err=1 and no bus access.
- REQ: mem_req=1. mem_addr/we/be/wdata are held stable until the cycle mem_gnt=1, then go to WAIT.
- WAIT: on mem_rvalid, capture data, go to RESP. Stores also wait for mem_rvalid (write ack).
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in REQ/WAIT/RESP.
- mem_rvalid outside WAIT is ignored. This includes a late response after a timeout.
- mem_gnt and mem_rvalid in the same cycle: gnt is honoured; that rvalid is ignored. The bus shall not do this.
- Minimum latency: accept at cycle 0, mem_req in cycle 1; with gnt in cycle 1 and rvalid in cycle 2, resp_valid is in cycle 3.
- Timeout: the counter increments in REQ/WAIT. At count==TIMEOUT_CYCLES-1 with no gnt/rvalid: drop mem_req, go to RESP with err=1, rdata=0.
- Byte lanes, o=addr[1:0]:
  - SB: be=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<(2*addr[1]), wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
  - Loads drive the same be with mem_we=0.
- Load extract: d = mem_rdata >> (8*o).
  - LB sign-extends d[7:0]; LBU zero-extends d[7:0].
  - LH sign-extends d[15:0]; LHU zero-extends d[15:0].
  - LW returns d.
- Reset asserted mid-transaction: mem_req drops and the FSM returns to IDLE immediately (async). No response is emitted.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined: a misaligned access (H with addr[0]=1; W with addr[1:0]≠0) skips the bus and goes to RESP with err=1, rdata=0.
- Undefined: misaligned low bits are forced to zero (H clears addr[0]; W clears addr[1:0]) and the access proceeds normally. The misalignment error source is absent.

Decomposition:
- pkg gets:
  - lsu_state_t enum {IDLE, REQ, WAIT, RESP};
  - funct3 constants F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101, F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010;
  - lsu_size_t enum {SZ_B, SZ_H, SZ_W}.
- One sub-module: lsu_load_align, purely combinational (rdata, offset, funct3 -> extended word). Shared with future misaligned-split support.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt same cycle, rvalid next -> mem_addr=0x100, be=1111, mem_we=1; resp_valid in cycle 3, rdata=0, err=0.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5. LB addr=0x103, mem_rdata=0x80FF0011 -> resp_rdata=0xFFFFFF80; LBU -> 0x00000080.
- LH addr=0x102, mem_rdata=0x9ABC1234 -> be=1100, resp_rdata=0xFFFF9ABC. LHU -> 0x00009ABC.
- gnt withheld 5 cycles -> mem_req and all mem_* stable for 5 cycles, req_ready=0 throughout. Then a normal response.
- TIMEOUT_CYCLES=8, no gnt -> resp_err=1 with rdata=0 at cycle 9. A late rvalid afterwards is ignored and a next request completes correctly.
- LW addr=0x102: with LSU_MISALIGN_EXC_EN -> err=1 and no mem_req ever. Without it -> mem_addr=0x100, normal LW. Also: reset pulse during WAIT -> mem_req=0, no resp_valid, req_ready=1.
